uart_rx_unit: RTL and testbench
===============================

Name: uart_rx_unit

Overview:
Serial receiver of the UART controller. It recovers frames from the RX line using the 16x oversampling baud tick and checks parity and stop bits. It delivers the data word with error flags to the register/FIFO layer. It also detects the configuration-request initialization signal (RX held low for 10 ms) and flags it to the main control FSM.

Parameters:
CFG_REQ_COUNT, COUNT_10MS (500_000 at 50 MHz), consecutive low clocks on RX that constitute a configuration request.

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
ov_baud_rt_i  input  1  single-cycle 16x oversampling tick
rx_i  input  1  asynchronous serial line, idle high
rx_enable_i  input  1  receiver enable
data_width_i  input  2  DW_5BIT..DW_8BIT
parity_mode_i  input  2  EVEN/ODD/DISABLED1/DISABLED2
stop_bits_i  input  2  SB_1BIT/SB_2BIT; RESERVED codes behave as SB_1BIT
data_rx_o  output  8  received word, right-aligned, zero-extended
rx_done_o  output  1  one-cycle pulse, frame complete
parity_error_o  output  1  parity error of last completed frame
frame_error_o  output  1  stop-bit error of last completed frame
config_req_o  output  1  one-cycle pulse, configuration request detected
rx_idle_o  output  1  FSM in RX_IDLE

Behaviour:
- Reset (async, rst_n_i=0):
  - State RX_IDLE.
  - 2-FF synchronizer on rx_i preset to 1.
  - data_rx_o=0; rx_done_o, parity_error_o, frame_error_o, config_req_o=0; rx_idle_o=1.
  - Tick counter, bit counter and 10 ms counter cleared.
- All sampling uses the synchronized rx. The tick counter (0..15) advances only on ov_baud_rt_i.
- FSM uses receiver_fsm_e.
  - RX_IDLE: if rx_enable_i=1 and synced rx=0:
    - latch data_width_i, parity_mode_i, stop_bits_i into internal registers; these hold for the whole frame.
    - clear tick counter; go to RX_START.
  - RX_START: on the 8th tick (mid start bit), sample rx.
    - rx=0: clear counter, go to RX_SAMPLE.
    - rx=1: glitch; return to RX_IDLE, no outputs change.
  - RX_SAMPLE: every 16th tick, sample one bit LSB-first into the shift register.
    - After 5+data_width bits: go to RX_PARITY if parity is EVEN/ODD, else RX_DONE.
  - RX_PARITY: on the 16th tick, sample the parity bit.
    - EVEN: error when XOR(data bits, parity bit)=1.
    - ODD: error when it =0.
  - RX_DONE: on the 16th tick, sample stop bit 1. With SB_2BIT, wait another 16 ticks and sample stop bit 2.
    - Frame error if any stop sample=0.
    - On the cycle after the final stop sample: pulse rx_done_o.
    - In that same cycle, update data_rx_o, parity_error_o and frame_error_o; they hold until the next completed frame.
    - Then go to RX_IDLE. Re-arming mid stop bit is intentional and permits back-to-back frames.
- Configuration request:
  - The 10 ms counter counts consecutive clocks with synced rx=0 in every state except RX_CONFIG_REQ. It clears whenever rx=1.
  - At reaching CFG_REQ_COUNT, from any state: abort the frame (no rx_done_o, outputs unchanged), pulse config_req_o for one cycle, enter RX_CONFIG_REQ.
  - RX_CONFIG_REQ: stay until synced rx=1, then go to RX_IDLE. Only one pulse per low period.
- rx_enable_i=0 mid-frame: abort to RX_IDLE next cycle, no rx_done_o. Config-request detection is active only while rx_enable_i=1.
- Config inputs changed mid-frame have no effect until the next start bit.
- Reset mid-frame: immediate return to reset values; partial frame is discarded.
- If rx_done_o and config detection coincide, config detection wins; rx_done_o is suppressed.

Test Plan:
- 8N1 (DW_8BIT, DISABLED1, SB_1BIT), send 0xA5 -> one rx_done_o pulse, data_rx_o=0xA5, parity_error_o=0, frame_error_o=0.
- 7E1, send 7'h55 with parity bit 1 (wrong; correct is 0) -> data_rx_o=0x55, parity_error_o=1. Next frame 7'h55 with parity 0 -> parity_error_o=0.
- 5O2, send 5'h13 with 2nd stop bit=0 -> data_rx_o=0x13, frame_error_o=1, parity_error_o=0 (odd parity correct).
- rx low for 4 ticks, then high -> stays in RX_IDLE, no rx_done_o, outputs unchanged. Then send 8'h3C -> received correctly.
- rx held low CFG_REQ_COUNT clocks (override to 1000 in sim) starting mid-frame -> exactly one config_req_o pulse, no rx_done_o. After rx returns high: rx_idle_o=1, and the next frame 0x16 is received correctly.
- Assert rst_n_i during RX_SAMPLE -> all outputs 0 asynchronously, rx_idle_o=1. After release, frame 0xFF is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// UART receiver result bundle.
// Carries the received word, status flags and idle state.
interface uart_rx_if;
  logic [7:0] data_rx_o;
  logic       rx_done_o;
  logic       parity_error_o;
  logic       frame_error_o;
  logic       config_req_o;
  logic       rx_idle_o;

  modport master (
    output data_rx_o,
    output rx_done_o,
    output parity_error_o,
    output frame_error_o,
    output config_req_o,
    output rx_idle_o
  );

  modport slave (
    input data_rx_o,
    input rx_done_o,
    input parity_error_o,
    input frame_error_o,
    input config_req_o,
    input rx_idle_o
  );
endinterface

// File: rtl/uart_rx_unit.sv
// UART serial receiver with 16x oversampling.
// Detects a long low line as a configuration request.
module uart_rx_unit #(
  parameter int unsigned CFG_REQ_COUNT = 500_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic       rx_enable_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic [1:0] stop_bits_i,
  uart_rx_if.master  rx_if
);

  localparam int unsigned CW =
    $clog2(CFG_REQ_COUNT + 1);
  localparam logic [CW-1:0] LOW_LAST =
    CW'(CFG_REQ_COUNT - 1);

  localparam logic [1:0] PM_ODD  = 2'd1;
  localparam logic [1:0] SB_2BIT = 2'd1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_SAMPLE,
    RX_PARITY,
    RX_DONE,
    RX_CONFIG_REQ
  } receiver_fsm_e;

  receiver_fsm_e state_q, state_d;

  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic [3:0]    tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          stop_idx_q, stop_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    dw_q, dw_d;
  logic [1:0]    pm_q, pm_d;
  logic [1:0]    sb_q, sb_d;
  logic          par_err_q, par_err_d;
  logic          frm_err_q, frm_err_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic [7:0]    data_rx_q, data_rx_d;
  logic          rx_done_q, rx_done_d;
  logic          parity_error_q, parity_error_d;
  logic          frame_error_q, frame_error_d;
  logic          config_req_q, config_req_d;

  logic       rx_s;
  logic       mid_tick;
  logic       end_tick;
  logic       par_en;
  logic       two_stop;
  logic       last_bit;
  logic       final_stop;
  logic       cfg_hit;
  logic       par_calc;
  logic [2:0] align;
  logic [7:0] word;

  assign rx_s     = rx_sync_q;
  assign mid_tick = ov_baud_rt_i
                 && (tick_cnt_q == 4'd7);
  assign end_tick = ov_baud_rt_i
                 && (tick_cnt_q == 4'd15);
  assign par_en   = !pm_q[1];
  assign two_stop = (sb_q == SB_2BIT);
  assign last_bit =
    (bit_cnt_q == (3'd4 + {1'b0, dw_q}));
  assign final_stop = (state_q == RX_DONE)
                   && end_tick
                   && (stop_idx_q || !two_stop);
  assign cfg_hit = rx_enable_i && !rx_s
                && (state_q != RX_CONFIG_REQ)
                && (low_cnt_q == LOW_LAST);
  assign par_calc = (^shift_q) ^ rx_s;
  assign align    = 3'd3 - {1'b0, dw_q};
  assign word     = shift_q >> align;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: frame sequencing, aborts win last.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE: begin
        if (rx_enable_i && !rx_s) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (mid_tick) begin
          state_d = rx_s ? RX_IDLE : RX_SAMPLE;
        end
      end
      RX_SAMPLE: begin
        if (end_tick && last_bit) begin
          state_d = par_en ? RX_PARITY : RX_DONE;
        end
      end
      RX_PARITY: begin
        if (end_tick) begin
          state_d = RX_DONE;
        end
      end
      RX_DONE: begin
        if (final_stop) begin
          state_d = RX_IDLE;
        end
      end
      RX_CONFIG_REQ: begin
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    if (!rx_enable_i) begin
      state_d = RX_IDLE;
    end
    if (cfg_hit) begin
      state_d = RX_CONFIG_REQ;
    end
  end

  // Datapath and output updates per state.
  always_comb begin
    rx_meta_d      = rx_i;
    rx_sync_d      = rx_meta_q;
    tick_cnt_d     = ov_baud_rt_i
                   ? tick_cnt_q + 4'd1
                   : tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    stop_idx_d     = stop_idx_q;
    shift_d        = shift_q;
    dw_d           = dw_q;
    pm_d           = pm_q;
    sb_d           = sb_q;
    par_err_d      = par_err_q;
    frm_err_d      = frm_err_q;
    data_rx_d      = data_rx_q;
    rx_done_d      = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    config_req_d   = cfg_hit;

    unique case (state_q)
      RX_IDLE: begin
        tick_cnt_d = 4'd0;
        if (rx_enable_i && !rx_s) begin
          dw_d       = data_width_i;
          pm_d       = parity_mode_i;
          sb_d       = stop_bits_i;
          shift_d    = 8'd0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
          stop_idx_d = 1'b0;
        end
      end
      RX_START: begin
        if (mid_tick) begin
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
        end
      end
      RX_SAMPLE: begin
        if (end_tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      RX_PARITY: begin
        if (end_tick) begin
          par_err_d = (pm_q == PM_ODD)
                    ? !par_calc : par_calc;
        end
      end
      RX_DONE: begin
        if (end_tick) begin
          stop_idx_d = 1'b1;
          frm_err_d  = frm_err_q | !rx_s;
        end
      end
      RX_CONFIG_REQ: begin
        tick_cnt_d = 4'd0;
      end
      default: tick_cnt_d = 4'd0;
    endcase

    if (final_stop && rx_enable_i && !cfg_hit) begin
      rx_done_d      = 1'b1;
      data_rx_d      = word;
      parity_error_d = par_err_q;
      frame_error_d  = frm_err_q | !rx_s;
    end

    if (!rx_enable_i || rx_s
        || (state_q == RX_CONFIG_REQ)) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_LAST) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end else begin
      low_cnt_d = low_cnt_q;
    end
  end

  // Datapath registers; line synchronizer presets high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      tick_cnt_q     <= 4'd0;
      bit_cnt_q      <= 3'd0;
      stop_idx_q     <= 1'b0;
      shift_q        <= 8'd0;
      dw_q           <= 2'd0;
      pm_q           <= 2'd0;
      sb_q           <= 2'd0;
      par_err_q      <= 1'b0;
      frm_err_q      <= 1'b0;
      low_cnt_q      <= '0;
      data_rx_q      <= 8'd0;
      rx_done_q      <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      config_req_q   <= 1'b0;
    end else begin
      rx_meta_q      <= rx_meta_d;
      rx_sync_q      <= rx_sync_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      stop_idx_q     <= stop_idx_d;
      shift_q        <= shift_d;
      dw_q           <= dw_d;
      pm_q           <= pm_d;
      sb_q           <= sb_d;
      par_err_q      <= par_err_d;
      frm_err_q      <= frm_err_d;
      low_cnt_q      <= low_cnt_d;
      data_rx_q      <= data_rx_d;
      rx_done_q      <= rx_done_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      config_req_q   <= config_req_d;
    end
  end

  assign rx_if.data_rx_o      = data_rx_q;
  assign rx_if.rx_done_o      = rx_done_q;
  assign rx_if.parity_error_o = parity_error_q;
  assign rx_if.frame_error_o  = frame_error_q;
  assign rx_if.config_req_o   = config_req_q;
  assign rx_if.rx_idle_o      = (state_q == RX_IDLE);

endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit.
// Frames push expectations; a monitor pops on rx_done.
module tb_uart_rx_unit;

  localparam int BIT = 256;

  logic       clk;
  logic       rst_n;
  logic       ov;
  logic       rx;
  logic       en;
  logic [1:0] dw;
  logic [1:0] pm;
  logic [1:0] sb;

  uart_rx_if rif ();

  uart_rx_unit #(
    .CFG_REQ_COUNT(1000)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .ov_baud_rt_i (ov),
    .rx_i         (rx),
    .rx_enable_i  (en),
    .data_width_i (dw),
    .parity_mode_i(pm),
    .stop_bits_i  (sb),
    .rx_if        (rif)
  );

  int vecs = 0;
  int miss = 0;
  int cfg_seen = 0;
  logic [9:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ov = 1'b0;
    forever begin
      repeat (15) @(negedge clk);
      ov = 1'b1;
      @(negedge clk);
      ov = 1'b0;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rif.rx_done_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("data", {24'd0, rif.data_rx_o},
            {24'd0, e[9:2]});
        chk("parity_err",
            {31'd0, rif.parity_error_o},
            {31'd0, e[1]});
        chk("frame_err",
            {31'd0, rif.frame_error_o},
            {31'd0, e[0]});
      end
    end
    if (rst_n && rif.config_req_o) cfg_seen++;
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(
    input logic [7:0] d, input int nb,
    input bit pen, input bit pbit,
    input bit two, input bit s_last,
    input bit epe, input bit efe);
    exp_q.push_back({d, epe, efe});
    hold(1'b0, BIT);
    for (int i = 0; i < nb; i++) hold(d[i], BIT);
    if (pen) hold(pbit, BIT);
    if (two) begin
      hold(1'b1, BIT);
      hold(s_last, BIT * 3 / 4);
    end else begin
      hold(s_last, BIT * 3 / 4);
    end
    hold(1'b1, BIT);
    chk("pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    en    = 1'b1;
    dw    = 2'd3;
    pm    = 2'd2;
    sb    = 2'd0;
    repeat (5) @(negedge clk);
    chk("rst_data", {24'd0, rif.data_rx_o}, 32'd0);
    chk("rst_done", {31'd0, rif.rx_done_o}, 32'd0);
    chk("rst_idle", {31'd0, rif.rx_idle_o}, 32'd1);
    chk("rst_cfg", {31'd0, rif.config_req_o}, 32'd0);
    rst_n = 1'b1;
    hold(1'b1, BIT);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 0, 0, 0, 1, 0, 0);

    // 7E1 0x55, wrong then right parity
    dw = 2'd2; pm = 2'd0; sb = 2'd0;
    send_frame(8'h55, 7, 1, 1, 0, 1, 1, 0);
    send_frame(8'h55, 7, 1, 0, 0, 1, 0, 0);

    // 5O2 0x13, second stop bit low
    dw = 2'd0; pm = 2'd1; sb = 2'd1;
    send_frame(8'h13, 5, 1, 0, 1, 0, 0, 1);

    // Short low glitch is rejected
    dw = 2'd3; pm = 2'd2; sb = 2'd0;
    hold(1'b0, 64);
    hold(1'b1, BIT);
    chk("glitch_idle", {31'd0, rif.rx_idle_o}, 32'd1);
    chk("glitch_data", {24'd0, rif.data_rx_o},
        32'h13);
    chk("glitch_ferr",
        {31'd0, rif.frame_error_o}, 32'd1);
    send_frame(8'h3C, 8, 0, 0, 0, 1, 0, 0);

    // Config request from mid-frame
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, 1100);
    chk("cfg_pulses", cfg_seen, 32'd1);
    chk("cfg_not_idle",
        {31'd0, rif.rx_idle_o}, 32'd0);
    chk("cfg_data", {24'd0, rif.data_rx_o}, 32'h3C);
    hold(1'b1, 8);
    chk("cfg_idle", {31'd0, rif.rx_idle_o}, 32'd1);
    hold(1'b1, BIT);
    send_frame(8'h16, 8, 0, 0, 0, 1, 0, 0);

    // Reset during data sampling
    hold(1'b0, BIT);
    hold(1'b1, BIT + 40);
    chk("sample_busy",
        {31'd0, rif.rx_idle_o}, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_data", {24'd0, rif.data_rx_o}, 32'd0);
    chk("arst_perr",
        {31'd0, rif.parity_error_o}, 32'd0);
    chk("arst_ferr",
        {31'd0, rif.frame_error_o}, 32'd0);
    chk("arst_idle", {31'd0, rif.rx_idle_o}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, BIT);
    send_frame(8'hFF, 8, 0, 0, 0, 1, 0, 0);

    chk("cfg_total", cfg_seen, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
